// File: rtl/timer_seq_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : timer_seq_pkg
//  Description : Shared types and constants for the timer burst sequencer.
//                Holds the sequencer state encoding, the register map of the
//                16-bit interval timer and its control-register bit positions.
//  Ports       : none (package)
//  Revision    : 1.0 - initial release
// ============================================================================
package timer_seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_WR_PL    = 3'd1,
        ST_WR_PH    = 3'd2,
        ST_WR_CTRL  = 3'd3,
        ST_WAIT_IRQ = 3'd4,
        ST_CLR_ST   = 3'd5,
        ST_STOP     = 3'd6,
        ST_DONE     = 3'd7
    } state_t;

    // Interval timer register map (word addresses)
    localparam logic [2:0] TMR_STATUS  = 3'd0;
    localparam logic [2:0] TMR_CONTROL = 3'd1;
    localparam logic [2:0] TMR_PERIODL = 3'd2;
    localparam logic [2:0] TMR_PERIODH = 3'd3;
    localparam logic [2:0] TMR_SNAPL   = 3'd4;
    localparam logic [2:0] TMR_SNAPH   = 3'd5;

    // Control register bit positions
    localparam int CTRL_ITO   = 0;
    localparam int CTRL_CONT  = 1;
    localparam int CTRL_START = 2;
    localparam int CTRL_STOP  = 3;

    function automatic logic [15:0] ctrl_bit(input int pos);
        return 16'd1 << pos;
    endfunction

    // Continuous run with interrupt enabled, and the halt word (ITO cleared)
    localparam logic [15:0] CTRL_RUN  = ctrl_bit(CTRL_ITO) | ctrl_bit(CTRL_CONT) | ctrl_bit(CTRL_START);
    localparam logic [15:0] CTRL_HALT = ctrl_bit(CTRL_STOP);

endpackage
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : rr_arbiter
//  Description : Round-robin arbiter. Combinational one-hot grant from the
//                current priority pointer; the pointer moves to the index
//                after the granted requester when advance_i is strobed.
//  Ports       : clk, reset      - clock, asynchronous active-high reset
//                req_i           - request vector
//                advance_i       - accept the current grant, rotate priority
//                grant_o         - one-hot grant (all zero when no request)
//  Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter #(
    parameter int NUM_REQ = 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_REQ-1:0] req_i,
    input  logic               advance_i,
    output logic [NUM_REQ-1:0] grant_o
);

    logic [1:0] ptr_q;
    logic [1:0] ptr_d;
    logic       found;

    // Two passes: first the requesters at or above the pointer, then wrap
    // around to the lowest index.
    always_comb begin
        grant_o = '0;
        found   = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!found && req_i[i] && (2'(i) >= ptr_q)) begin
                grant_o[i] = 1'b1;
                found      = 1'b1;
            end
        end
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!found && req_i[i]) begin
                grant_o[i] = 1'b1;
                found      = 1'b1;
            end
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (advance_i) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (grant_o[i]) begin
                    ptr_d = (i == NUM_REQ - 1) ? 2'd0 : 2'(i + 1);
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr_q <= 2'd0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/timer_burst_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : timer_burst_sequencer
//  Description : Shares one 16-bit interval timer between NUM_REQ requesters.
//                A granted requester's burst programs the period, starts the
//                timer in continuous mode, services req_count interrupts
//                (one tick each), then stops the timer and reports done.
//  Ports       : clk, reset                 - clock, async active-high reset
//                req_valid/req_ready        - per-requester handshake
//                req_period/req_count       - per-requester burst parameters
//                abort                      - terminate the active burst
//                tick                       - one pulse per serviced timeout
//                done/done_aborted          - burst end pulse to owner + cause
//                busy, owner                - status
//                tmr_address..tmr_writedata - write-only Avalon-MM master
//                tmr_irq                    - timer interrupt (level)
//  Revision    : 1.0 - initial release
// ============================================================================
module timer_burst_sequencer
    import timer_seq_pkg::*;
#(
    parameter int NUM_REQ    = 2,
    parameter int MIN_PERIOD = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NUM_REQ-1:0]    req_valid,
    output logic [NUM_REQ-1:0]    req_ready,
    input  logic [32*NUM_REQ-1:0] req_period,
    input  logic [16*NUM_REQ-1:0] req_count,
    input  logic                  abort,
    output logic                  tick,
    output logic [NUM_REQ-1:0]    done,
    output logic                  done_aborted,
    output logic                  busy,
    output logic [1:0]            owner,
    output logic [2:0]            tmr_address,
    output logic                  tmr_chipselect,
    output logic                  tmr_write_n,
    output logic [15:0]           tmr_writedata,
    input  logic                  tmr_irq
);

    state_t        state_q, state_d;
    logic [31:0]   period_q, period_d;
    logic [15:0]   remaining_q, remaining_d;
    logic [1:0]    owner_q, owner_d;
    logic          aborted_q, aborted_d;

    logic [NUM_REQ-1:0] grant;
    logic               advance;
    logic [31:0]        sel_period;
    logic [15:0]        sel_count;
    logic [1:0]         sel_idx;

    // Acceptance only in IDLE; held off while reset is asserted so that the
    // handshake output is quiet during reset even with requests pending.
    assign advance   = (state_q == ST_IDLE) && (|req_valid) && !reset;
    assign req_ready = advance ? grant : '0;
    assign busy      = (state_q != ST_IDLE);
    assign owner     = owner_q;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_arb (
        .clk       (clk),
        .reset     (reset),
        .req_i     (req_valid),
        .advance_i (advance),
        .grant_o   (grant)
    );

    // Select the winner's burst parameters
    always_comb begin
        sel_period = '0;
        sel_count  = '0;
        sel_idx    = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                sel_period = req_period[32*i +: 32];
                sel_count  = req_count[16*i +: 16];
                sel_idx    = 2'(i);
            end
        end
    end

    always_comb begin
        state_d        = state_q;
        period_d       = period_q;
        remaining_d    = remaining_q;
        owner_d        = owner_q;
        aborted_d      = aborted_q;
        tick           = 1'b0;
        done           = '0;
        done_aborted   = 1'b0;
        tmr_address    = 3'd0;
        tmr_chipselect = 1'b0;
        tmr_write_n    = 1'b1;
        tmr_writedata  = 16'h0000;

        case (state_q)
            ST_IDLE: begin
                if (advance) begin
                    period_d    = (sel_period < 32'(MIN_PERIOD)) ? 32'(MIN_PERIOD) : sel_period;
                    remaining_d = (sel_count == 16'd0) ? 16'd1 : sel_count;
                    owner_d     = sel_idx;
                    aborted_d   = 1'b0;
                    state_d     = ST_WR_PL;
                end
            end
            ST_WR_PL: begin
                tmr_chipselect = 1'b1;
                tmr_write_n    = 1'b0;
                tmr_address    = TMR_PERIODL;
                tmr_writedata  = period_q[15:0];
                state_d        = ST_WR_PH;
            end
            ST_WR_PH: begin
                tmr_chipselect = 1'b1;
                tmr_write_n    = 1'b0;
                tmr_address    = TMR_PERIODH;
                tmr_writedata  = period_q[31:16];
                state_d        = ST_WR_CTRL;
            end
            ST_WR_CTRL: begin
                tmr_chipselect = 1'b1;
                tmr_write_n    = 1'b0;
                tmr_address    = TMR_CONTROL;
                tmr_writedata  = CTRL_RUN;
                state_d        = ST_WAIT_IRQ;
            end
            ST_WAIT_IRQ: begin
                if (tmr_irq) begin
                    state_d = ST_CLR_ST;
                end
            end
            ST_CLR_ST: begin
                // Status write acknowledges the timeout and drops the irq
                tmr_chipselect = 1'b1;
                tmr_write_n    = 1'b0;
                tmr_address    = TMR_STATUS;
                tmr_writedata  = 16'h0000;
                tick           = 1'b1;
                remaining_d    = remaining_q - 16'd1;
                state_d        = (remaining_q <= 16'd1) ? ST_STOP : ST_WAIT_IRQ;
            end
            ST_STOP: begin
                tmr_chipselect = 1'b1;
                tmr_write_n    = 1'b0;
                tmr_address    = TMR_CONTROL;
                tmr_writedata  = CTRL_HALT;
                state_d        = ST_DONE;
            end
            ST_DONE: begin
                for (int i = 0; i < NUM_REQ; i++) begin
                    if (owner_q == 2'(i)) begin
                        done[i] = 1'b1;
                    end
                end
                done_aborted = aborted_q;
                state_d      = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Abort overrides the successor of any active-burst state but never
        // suppresses the write issued in the current cycle; a coincident irq
        // in WAIT_IRQ therefore produces no tick.
        if (abort && (state_q inside {ST_WR_PL, ST_WR_PH, ST_WR_CTRL, ST_WAIT_IRQ, ST_CLR_ST})) begin
            state_d   = ST_STOP;
            aborted_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            period_q    <= '0;
            remaining_q <= '0;
            owner_q     <= '0;
            aborted_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            period_q    <= period_d;
            remaining_q <= remaining_d;
            owner_q     <= owner_d;
            aborted_q   <= aborted_d;
        end
    end

endmodule
`default_nettype wire

// File: doc/timer_burst_sequencer.md
TIMER_BURST_SEQUENCER -- requirements
Module: timer_burst_sequencer

Interface
REQ-001 SHALL have parameter NUM_REQ, default 2, meaning number of requesters sharing the interval timer (2..4).
REQ-002 SHALL have parameter MIN_PERIOD, default 2, meaning the smallest period value ever written to the timer.
REQ-003 SHALL have port clk, input, 1, the single clock for the whole block.
REQ-004 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-005 SHALL have port req_valid, input, NUM_REQ, per-requester burst request, held until accepted.
REQ-006 SHALL have port req_ready, output, NUM_REQ, one-cycle acceptance strobe per requester.
REQ-007 SHALL have port req_period, input, 32*NUM_REQ, per-requester timer period in clk cycles.
REQ-008 SHALL have port req_count, input, 16*NUM_REQ, per-requester number of timeouts in the burst.
REQ-009 SHALL have port abort, input, 1, terminates the active burst.
REQ-010 SHALL have port tick, output, 1, one-cycle pulse per serviced timeout.
REQ-011 SHALL have port done, output, NUM_REQ, one-cycle pulse to the owner at burst end.
REQ-012 SHALL have port done_aborted, output, 1, qualifies done; high when the burst ended by abort.
REQ-013 SHALL have port busy, output, 1, high in every state except IDLE.
REQ-014 SHALL have port owner, output, 2, index of the current or last granted requester.
REQ-015 SHALL have ports tmr_address (out, 3), tmr_chipselect (out, 1), tmr_write_n (out, 1), tmr_writedata (out, 16), forming a write-only Avalon-MM master to the 16-bit interval timer; no waitrequest.
REQ-016 SHALL have port tmr_irq, input, 1, the timer interrupt (level, cleared by a status write).

Function
REQ-017 SHALL implement FSM states IDLE, WR_PL, WR_PH, WR_CTRL, WAIT_IRQ, CLR_ST, STOP, DONE.
REQ-018 IDLE: when any req_valid is high, SHALL pulse req_ready of the round-robin winner in that cycle, latch its period/count/index, and go to WR_PL.
REQ-019 Round-robin: priority SHALL start at requester 0 after reset and move to the index after the last granted one.
REQ-020 WR_PL/WR_PH/WR_CTRL SHALL each issue exactly one single-cycle write: address 2 data period[15:0], address 3 data period[31:16], address 1 data 0x0007 (ITO|CONT|START).
REQ-021 A latched period below MIN_PERIOD SHALL be replaced by MIN_PERIOD; a count of 0 SHALL be treated as 1.
REQ-022 WAIT_IRQ: on tmr_irq high SHALL go to CLR_ST; otherwise remain.
REQ-023 CLR_ST SHALL write address 0 data 0x0000, pulse tick, decrement the remaining count, then go to STOP if it reaches 0, else to WAIT_IRQ.
REQ-024 STOP SHALL write address 1 data 0x0008 (STOP, ITO cleared) and go to DONE.
REQ-025 DONE SHALL pulse done[owner], with done_aborted valid in the same cycle, then return to IDLE; no request is accepted in DONE.
REQ-026 abort high in WR_PL..CLR_ST SHALL, after that cycle's write, force the next state to STOP and set done_aborted; abort in IDLE, STOP or DONE SHALL be ignored.
REQ-027 abort and tmr_irq high together in WAIT_IRQ: abort SHALL win; no tick.
REQ-028 When no write is issued, tmr_chipselect SHALL be 0, tmr_write_n 1, tmr_writedata 0.
REQ-029 Deasserting req_valid before acceptance SHALL withdraw the request without side effects.

Reset
REQ-030 Reset SHALL force IDLE, req_ready=0, tick=0, done=0, done_aborted=0, busy=0, owner=0, tmr_chipselect=0, tmr_write_n=1, tmr_writedata=0, round-robin pointer=0, remaining count=0.
REQ-031 Reset mid-burst SHALL abandon the burst without issuing a STOP write and without a done pulse.

Structure
REQ-032 Package timer_seq_pkg SHALL hold the state enum, timer register addresses (STATUS=0, CONTROL=1, PERIODL=2, PERIODH=3, SNAPL=4, SNAPH=5), and control bit constants (ITO=0, CONT=1, START=2, STOP=3).
REQ-033 Arbitration SHALL be the sub-module rr_arbiter (NUM_REQ requests, grant one-hot, advance strobe).

Verification
REQ-034 Req0 period 0x00015F8F count 3 -> writes (2,0x5F8F),(3,0x0001),(1,0x0007) on three consecutive cycles after ready; 3 ticks on 3 irqs; (1,0x0008); done[0], done_aborted=0.
REQ-035 Req0 and req1 valid in the same cycle from reset -> req0 granted first, req1 granted in the first IDLE cycle after done[0].
REQ-036 Req period 1, count 0 -> PERIODL write data 0x0002, PERIODH 0x0000, exactly one tick before STOP.
REQ-037 abort with tmr_irq in WAIT_IRQ of a count-5 burst -> no tick, STOP write next, done with done_aborted=1.
REQ-038 Reset asserted in WAIT_IRQ -> all outputs at reset values immediately; no STOP write and no done pulse after release.
